fir_out_buffer: RTL and testbench

- Elastic AXI-Stream buffer directly downstream of the FIR core's stream output (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Absorbs consumer back-pressure so the FIR pipeline keeps running.
- Checks frame length against the programmed data length (the value written to register 0x10, 600 in the standard run).
- Reports fill level, frame completion and length errors.

---
 rtl/fir_out_buffer.sv | 146 ++++++++++++++
 tb/tb_fir_out_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_buffer.sv
// -----------------------------------------------------------------------------
// fir_out_buffer
//   Elastic AXI-Stream buffer placed right after the FIR core's stream output.
//   It soaks up consumer back-pressure so the FIR pipeline keeps running. It
//   also checks each input frame's length against the programmed data length
//   and reports fill level, completed frames and length errors.
//
// Ports
//   axis_clk, axis_rst_n  clock (rising edge), asynchronous active-low reset
//   cfg_len               expected samples per frame, taken at a frame's first beat
//   s_tvalid/s_tdata/s_tlast/s_tready   input stream (from the FIR core)
//   m_tvalid/m_tdata/m_tlast/m_tready   output stream (first-word fall-through)
//   fifo_level            occupancy, 0 .. 2**pDEPTH_LOG2
//   frame_cnt             frames fully drained on the output side (wraps)
//   frame_done            one-cycle pulse after the output handshake of a tlast beat
//   len_err               sticky frame-length mismatch flag
// -----------------------------------------------------------------------------
module fir_out_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH_LOG2 = 4,
  parameter int pLEN_WIDTH  = 10
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [pDEPTH_LOG2:0]   fifo_level,
  output logic [15:0]            frame_cnt,
  output logic                   frame_done,
  output logic                   len_err
);

  localparam int DEPTH = 1 << pDEPTH_LOG2;
  localparam logic [pDEPTH_LOG2:0] LVL_FULL = (pDEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [pDEPTH_LOG2:0] LVL_ONE  = (pDEPTH_LOG2 + 1)'(1);
  localparam logic [pDEPTH_LOG2-1:0] PTR_ONE = pDEPTH_LOG2'(1);

  // Storage entries are {tlast, tdata}
  logic [pDATA_WIDTH:0]   mem_q [DEPTH];
  logic [pDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [pDEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [pDEPTH_LOG2:0]   level_q, level_d;
  logic                   rdy_en_q;
  logic [pLEN_WIDTH-1:0]  scnt_q, scnt_d;
  logic [pLEN_WIDTH-1:0]  len_q, len_d;
  logic                   len_err_q, len_err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   frame_done_q, frame_done_d;

  logic                   push, pop;
  logic [pDATA_WIDTH:0]   head;
  logic [pLEN_WIDTH-1:0]  eff_len;
  logic [pLEN_WIDTH:0]    cnt_nx;
  logic                   mismatch;

  // rdy_en_q holds s_tready low while in reset and lets it rise on the first
  // edge afterwards; past that point only a full FIFO blocks the input.
  assign s_tready = rdy_en_q & (level_q != LVL_FULL);
  assign m_tvalid = (level_q != '0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  // The head is gated so the outputs read zero whenever the FIFO is empty
  assign head     = mem_q[rd_ptr_q];
  assign m_tdata  = m_tvalid ? head[pDATA_WIDTH-1:0] : '0;
  assign m_tlast  = m_tvalid & head[pDATA_WIDTH];

  assign fifo_level = level_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

  // On the first beat cfg_len is not yet in len_q, so it is compared directly.
  // cnt_nx has one extra bit so scnt+1 cannot wrap onto a small cfg_len.
  assign eff_len = (scnt_q == '0) ? cfg_len : len_q;
  assign cnt_nx  = {1'b0, scnt_q} + (pLEN_WIDTH + 1)'(1);
  assign mismatch = (eff_len != '0) &&
                    (s_tlast ? (cnt_nx != {1'b0, eff_len})
                             : (cnt_nx == {1'b0, eff_len}));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    scnt_d       = scnt_q;
    len_d        = len_q;
    len_err_d    = len_err_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (scnt_q == '0) len_d = cfg_len;
      scnt_d = s_tlast ? '0 : cnt_nx[pLEN_WIDTH-1:0];
      if (mismatch) len_err_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (head[pDATA_WIDTH]) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
      end
    end

    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rdy_en_q     <= 1'b0;
      scnt_q       <= '0;
      len_q        <= '0;
      len_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rdy_en_q     <= 1'b1;
      scnt_q       <= scnt_d;
      len_q        <= len_d;
      len_err_q    <= len_err_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload storage is not reset; only entries below the level are ever shown
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
module tb_fir_out_buffer;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic [9:0]  cfg_len;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [4:0]  fifo_level;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  int max_lvl = 0;
  int done_cnt = 0;
  logic [32:0] q[$];

  fir_out_buffer #(.pDATA_WIDTH(32), .pDEPTH_LOG2(4), .pLEN_WIDTH(10)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_len(cfg_len),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .fifo_level(fifo_level), .frame_cnt(frame_cnt), .frame_done(frame_done),
    .len_err(len_err)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        r;
    logic [4:0]  lvl;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic        sr;
    logic        done;
  } vec_t;

  vec_t tbl [8];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    axis_rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    q.delete();
    max_lvl = 0;
    done_cnt = 0;
  endtask

  // One clock with a reference-queue scoreboard on both stream sides
  task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                     input logic r, output logic pushed);
    logic push, pop;
    logic [32:0] e;
    e = '0;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    #1;
    push = s_tvalid & s_tready;
    pop  = m_tvalid & m_tready;
    if (pop) begin
      if (q.size() == 0) begin
        chk("pop_on_empty_model", 1, 0);
      end else begin
        e = q.pop_front();
        chk("m_tdata", m_tdata, e[31:0]);
        chk("m_tlast", m_tlast, e[32]);
      end
    end
    if (push) q.push_back({l, d});
    @(posedge axis_clk); #1;
    chk("fifo_level", fifo_level, q.size());
    chk("m_tvalid", m_tvalid, q.size() != 0);
    chk("s_tready", s_tready, q.size() < 16);
    chk("frame_done", frame_done, pop && e[32]);
    if (q.size() > max_lvl) max_lvl = q.size();
    if (frame_done) done_cnt++;
    pushed = push;
  endtask

  // mode 0: consumer always ready; mode 1: ready toggles every 16 cycles
  task automatic run_frame(input int n, input int last_idx, input int mode, input int base);
    int sent = 0;
    int cn = 0;
    logic p;
    while ((sent < n || q.size() != 0) && cn < 4000) begin
      cyc(sent < n, 32'(base + sent), sent == last_idx,
          (mode == 0) ? 1'b1 : ((cn / 16) % 2 == 1), p);
      if (p) sent++;
      cn++;
    end
    chk("frame_timeout", cn < 4000, 1);
  endtask

  initial begin
    logic p;
    axis_rst_n = 1'b0;
    cfg_len = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;

    //                v  d             l  r  lvl mv md            ml sr done
    tbl[0] = '{1'b1, 32'h000000A1, 1'b0, 1'b0, 5'd1, 1'b1, 32'h000000A1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h000000A2, 1'b0, 1'b0, 5'd2, 1'b1, 32'h000000A1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'h000000A3, 1'b1, 1'b1, 5'd2, 1'b1, 32'h000000A2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 5'd1, 1'b1, 32'h000000A3, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 5'd1, 1'b1, 32'h000000A3, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 5'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 5'd1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 5'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};

    // Reset state
    @(posedge axis_clk); #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_len_err", len_err, 0);
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    chk("idle_s_tready", s_tready, 1);
    chk("idle_m_tvalid", m_tvalid, 0);
    chk("idle_level", fifo_level, 0);
    chk("idle_len_err", len_err, 0);

    // Directed vectors, length check disabled
    cfg_len = 10'd0;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tlast = tbl[i].l; m_tready = tbl[i].r;
      @(posedge axis_clk); #1;
      chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, tbl[i].mv);
      chk($sformatf("vec%0d_m_tdata", i), m_tdata, tbl[i].md);
      chk($sformatf("vec%0d_m_tlast", i), m_tlast, tbl[i].ml);
      chk($sformatf("vec%0d_s_tready", i), s_tready, tbl[i].sr);
      chk($sformatf("vec%0d_frame_done", i), frame_done, tbl[i].done);
    end
    chk("vec_frame_cnt", frame_cnt, 2);
    chk("vec_len_err", len_err, 0);

    // 600-beat pass-through, consumer always ready
    do_reset();
    cfg_len = 10'd600;
    run_frame(600, 599, 0, 0);
    chk("pass_frame_cnt", frame_cnt, 1);
    chk("pass_done_cnt", done_cnt, 1);
    chk("pass_len_err", len_err, 0);
    chk("pass_max_level", max_lvl <= 1, 1);

    // Fill to full, then a single pop
    do_reset();
    cfg_len = 10'd0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(1000 + i), 1'b0, 1'b0, p);
    chk("full_level", fifo_level, 16);
    chk("full_s_tready", s_tready, 0);
    cyc(1'b1, 32'd2000, 1'b0, 1'b1, p);
    chk("full_pop_no_push", p, 0);
    chk("full_pop_level", fifo_level, 15);
    chk("full_pop_s_tready", s_tready, 1);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b0, 1'b1, p);
    chk("full_drained", fifo_level, 0);

    // 600-beat frame, consumer ready toggling every 16 cycles
    do_reset();
    cfg_len = 10'd600;
    run_frame(600, 599, 1, 5000);
    chk("toggle_frame_cnt", frame_cnt, 1);
    chk("toggle_len_err", len_err, 0);

    // tlast arriving one beat early
    do_reset();
    cfg_len = 10'd600;
    run_frame(598, -1, 0, 0);
    chk("early_before", len_err, 0);
    run_frame(1, 0, 0, 598);
    chk("early_after", len_err, 1);

    // tlast missing at the expected beat
    do_reset();
    cfg_len = 10'd600;
    run_frame(599, -1, 0, 0);
    chk("late_before", len_err, 0);
    run_frame(1, -1, 0, 599);
    chk("late_after", len_err, 1);

    // Simultaneous push/pop at level 5 with the write pointer crossing 15->0
    do_reset();
    cfg_len = 10'd0;
    for (int i = 0; i < 13; i++) cyc(1'b1, 32'(300 + i), 1'b0, 1'b0, p);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b1, p);
    for (int i = 0; i < 2; i++)  cyc(1'b1, 32'(313 + i), 1'b0, 1'b0, p);
    chk("wrap_level5", fifo_level, 5);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'(400 + i), i == 7, 1'b1, p);
      chk($sformatf("wrap_pp%0d_level", i), fifo_level, 5);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, 1'b1, p);
    chk("wrap_drained", fifo_level, 0);
    chk("wrap_frame_cnt", frame_cnt, 1);

    // Reset in the middle of a frame at level 7
    do_reset();
    cfg_len = 10'd600;
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'(700 + i), 1'b0, 1'b0, p);
    chk("midrst_pre_level", fifo_level, 7);
    axis_rst_n = 1'b0;
    #1;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s_tready", s_tready, 0);
    do_reset();
    // Sample counter must restart, so a clean 3-beat frame raises no error
    cfg_len = 10'd3;
    run_frame(3, 2, 0, 0);
    chk("midrst_len_err", len_err, 0);
    chk("midrst_frame_cnt", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
